// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM, single-entry
// valid/ready holding register with framing and overrun error pulses.

module uart_rx_param_chk #(
    parameter int TICKS_PER_BIT = 4
) ();
    generate
        if (TICKS_PER_BIT < 4) begin : g_ticks_too_small
            $error("uart_rx: CLK_FREQ_HZ / BAUD_RATE must be at least 4");
        end
    endgenerate
endmodule

module uart_rx #(
    parameter int CLK_FREQ_HZ = 0,
    parameter int BAUD_RATE   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    output logic [7:0] byte_out_data,
    output logic       byte_out_valid,
    input  logic       byte_out_ready,
    output logic       frame_err,
    output logic       overrun_err
);

    localparam int TICKS_PER_BIT = (BAUD_RATE > 0) ? (CLK_FREQ_HZ / BAUD_RATE) : 0;
    localparam int HALF          = TICKS_PER_BIT / 2;
    localparam int CW            = $clog2(TICKS_PER_BIT) + 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(1'b0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } state_t;

    uart_rx_param_chk #(.TICKS_PER_BIT(TICKS_PER_BIT)) u_param_chk ();

    logic [1:0]    sync_r;
    logic          bit_s;
    state_t        state_r, state_nx;
    logic [CW-1:0] cnt_r, cnt_nx;
    logic [2:0]    idx_r, idx_nx;
    logic [7:0]    shift_r, shift_nx;
    logic [7:0]    data_r, data_nx;
    logic          valid_r, valid_nx;
    logic          frame_err_r, frame_err_nx;
    logic          overrun_err_r, overrun_err_nx;

    // Two-flop synchroniser for the asynchronous line; deliberately not reset.
    always_ff @(posedge clk) begin
        sync_r <= {sync_r[0], bit_in};
    end

    assign bit_s = sync_r[1];

    // Next-state, counter, shift register and holding-register logic.
    always_comb begin
        state_nx       = state_r;
        cnt_nx         = cnt_r;
        idx_nx         = idx_r;
        shift_nx       = shift_r;
        data_nx        = data_r;
        frame_err_nx   = 1'b0;
        overrun_err_nx = 1'b0;
        if (valid_r && byte_out_ready) begin
            valid_nx = 1'b0;
        end else begin
            valid_nx = valid_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (bit_s) begin
                    cnt_nx   = CNT_ZERO;
                    state_nx = ST_START;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == HALF_LAST) begin
                    // A start bit that has vanished by mid-bit is treated as a glitch.
                    if (bit_s) begin
                        cnt_nx   = CNT_ZERO;
                        idx_nx   = 3'd0;
                        state_nx = ST_DATA;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else begin
                    cnt_nx = cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_r == TICK_LAST) begin
                    shift_nx = {bit_s, shift_r[7:1]};
                    cnt_nx   = CNT_ZERO;
                    idx_nx   = idx_r + 3'd1;
                    if (idx_r == 3'd7) begin
                        state_nx = ST_STOP;
                    end else begin
                        state_nx = ST_DATA;
                    end
                end else begin
                    cnt_nx = cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_r == TICK_LAST) begin
                    cnt_nx   = CNT_ZERO;
                    state_nx = ST_WAIT_IDLE;
                    if (!bit_s) begin
                        frame_err_nx = 1'b1;
                    end else if (!valid_r || byte_out_ready) begin
                        data_nx  = shift_r;
                        valid_nx = 1'b1;
                    end else begin
                        overrun_err_nx = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt_r + CNT_ONE;
                end
            end
            ST_WAIT_IDLE: begin
                // Hold off until the line drops so the stop bit cannot re-trigger a start.
                if (!bit_s) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_WAIT_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = CNT_ZERO;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO;
            idx_r         <= 3'd0;
            shift_r       <= 8'h00;
            data_r        <= 8'h00;
            valid_r       <= 1'b0;
            frame_err_r   <= 1'b0;
            overrun_err_r <= 1'b0;
        end else begin
            state_r       <= state_nx;
            cnt_r         <= cnt_nx;
            idx_r         <= idx_nx;
            shift_r       <= shift_nx;
            data_r        <= data_nx;
            valid_r       <= valid_nx;
            frame_err_r   <= frame_err_nx;
            overrun_err_r <= overrun_err_nx;
        end
    end

    assign byte_out_data  = data_r;
    assign byte_out_valid = valid_r;
    assign frame_err      = frame_err_r;
    assign overrun_err    = overrun_err_r;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a behavioural line driver queues expected bytes
// and error counts; a negedge monitor pops and compares what the DUT presents.
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int CLK_HZ = 16_000_000;
    localparam int BAUD   = 1_000_000;
    localparam int T      = CLK_HZ / BAUD;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in;
    logic [7:0] byte_out_data;
    logic       byte_out_valid;
    logic       byte_out_ready;
    logic       frame_err;
    logic       overrun_err;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [7:0] exp_q[$];
    int         exp_frame = 0, exp_overrun = 0;
    int         obs_frame = 0, obs_overrun = 0;
    bit         model_pending = 1'b0;
    bit         lat_armed = 1'b0;
    int         lat_start = 0;

    uart_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
        .clk            (clk),
        .rst            (rst),
        .bit_in         (bit_in),
        .byte_out_data  (byte_out_data),
        .byte_out_valid (byte_out_valid),
        .byte_out_ready (byte_out_ready),
        .frame_err      (frame_err),
        .overrun_err    (overrun_err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_range(input string nm, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // Behavioural transmitter: frame = start(1), 8 data LSB first, stop, then idle gap.
    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input int gap_bits, input int abort_at);
        logic [9:0] frame;
        frame = {stop_v, b, 1'b1};
        if (abort_at < 0) begin
            if (!stop_v) begin
                exp_frame++;
            end else if (!byte_out_ready && model_pending) begin
                exp_overrun++;
            end else begin
                exp_q.push_back(b);
                model_pending = !byte_out_ready;
            end
        end
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < T; c++) begin
                bit_in = frame[i];
                if (i == abort_at && c == T / 2) rst = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        bit_in = 1'b0;
        repeat (gap_bits * T) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: consume beats, count error pulses, check hold stability and latency.
    initial begin
        logic       prev_valid = 1'b0;
        logic       prev_ready = 1'b0;
        logic [7:0] prev_data  = 8'h00;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (byte_out_valid && byte_out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got 0x%0h expected no byte", byte_out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 32'(byte_out_data), 32'(e));
                end
            end
            if (prev_valid && !prev_ready && byte_out_valid)
                chk("hold_stable", 32'(byte_out_data), 32'(prev_data));
            if (frame_err && overrun_err)
                chk("err_exclusive", 32'({frame_err, overrun_err}), 32'd0);
            if (frame_err) obs_frame++;
            if (overrun_err) obs_overrun++;
            if (lat_armed && byte_out_valid) begin
                lat_armed = 1'b0;
                chk_range("latency", cyc - lat_start, 2 + T/2 + 9*T - 1, 2 + T/2 + 9*T + 3);
            end
            prev_valid = byte_out_valid;
            prev_ready = byte_out_ready;
            prev_data  = byte_out_data;
        end
    end

    initial begin
        rst            = 1'b0;
        bit_in         = 1'b0;
        byte_out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", 32'(byte_out_valid), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);
        chk("reset_overrun_err", 32'(overrun_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (4) begin @(posedge clk); #1; end

        // Single frame with latency measurement.
        lat_start = cyc;
        lat_armed = 1'b1;
        send_frame(8'hA5, 1'b1, 2, -1);
        chk("t1_latency_seen", 32'(lat_armed), 32'd0);

        // Back-to-back frames with one idle bit.
        send_frame(8'h00, 1'b1, 1, -1);
        send_frame(8'hFF, 1'b1, 1, -1);
        chk("t2_drained", 32'(exp_q.size()), 32'd0);

        // Short high glitch must not produce anything.
        bit_in = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        bit_in = 1'b0;
        repeat (3 * T) begin @(posedge clk); #1; end
        chk("t3_no_frame_err", 32'(obs_frame), 32'd0);
        chk("t3_no_overrun", 32'(obs_overrun), 32'd0);
        send_frame(8'h3C, 1'b1, 2, -1);

        // Stop bit low: framing error, no data.
        send_frame(8'h81, 1'b0, 2, -1);
        chk("t4_frame_err_cycles", 32'(obs_frame), 32'd1);

        // Overrun while the consumer stalls.
        byte_out_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1, -1);
        send_frame(8'h22, 1'b1, 2, -1);
        @(negedge clk);
        chk("t5_valid_held", 32'(byte_out_valid), 32'd1);
        chk("t5_data_held", 32'(byte_out_data), 32'h11);
        chk("t5_overrun_cycles", 32'(obs_overrun), 32'd1);
        @(posedge clk);
        #1;
        byte_out_ready = 1'b1;
        model_pending  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t5_valid_dropped", 32'(byte_out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Reset during data bit 4, held until the aborted frame has passed.
        send_frame(8'h0F, 1'b1, 2, 5);
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("t6_no_frame_err", 32'(obs_frame), 32'd1);
        chk("t6_no_overrun", 32'(obs_overrun), 32'd1);
        chk("t6_valid_after_reset", 32'(byte_out_valid), 32'd0);
        send_frame(8'h5A, 1'b1, 2, -1);

        // Loopback sweep of every byte value.
        for (int v = 0; v < 256; v++) send_frame(8'(v), 1'b1, 1, -1);

        // Random bytes with random idle gaps.
        for (int k = 0; k < 16; k++)
            send_frame(8'($urandom_range(0, 255)), 1'b1, int'($urandom_range(1, 3)), -1);

        for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("final_frame_err_count", 32'(obs_frame), 32'(exp_frame));
        chk("final_overrun_count", 32'(obs_overrun), 32'(exp_overrun));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
